// File: rtl/traffic_phase_sched.sv
// Two-road intersection phase scheduler: green/yellow/clearance sequencing,
// latched pedestrian WALK phase and emergency drain to all-red.
module traffic_phase_sched #(
  parameter int GREEN_T   = 30,
  parameter int YELLOW_T  = 5,
  parameter int CLEAR_T   = 2,
  parameter int WALK_T    = 12,
  parameter int MIN_GREEN = 10,
  parameter int CW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          ped_req,
  input  logic          emerg,
  output logic          ns_red,
  output logic          ns_yellow,
  output logic          ns_green,
  output logic          ew_red,
  output logic          ew_yellow,
  output logic          ew_green,
  output logic          walk,
  output logic [CW-1:0] remain,
  output logic [2:0]    state,
  output logic          ped_pending
);

  typedef enum logic [2:0] {
    S_NS_G  = 3'd0,
    S_NS_Y  = 3'd1,
    S_CLR1  = 3'd2,
    S_EW_G  = 3'd3,
    S_EW_Y  = 3'd4,
    S_CLR2  = 3'd5,
    S_WALK  = 3'd6,
    S_EMERG = 3'd7
  } phase_t;

  localparam logic [CW-1:0] G_LD     = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] Y_LD     = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] C_LD     = CW'(CLEAR_T - 1);
  localparam logic [CW-1:0] W_LD     = CW'(WALK_T - 1);
  localparam logic [CW-1:0] TRUNC_AT = CW'(GREEN_T - MIN_GREEN);
  localparam logic [CW-1:0] ONE      = CW'(1);

  phase_t cur;
  logic   expire;
  logic   cut_green;
  logic   enter_walk;

  assign state      = cur;
  assign expire     = tick && (remain == '0);
  // A pending walk may end green early once the minimum green has elapsed.
  assign cut_green  = tick && ped_pending && (remain <= TRUNC_AT);
  assign enter_walk = (cur == S_CLR2) && expire && !emerg && ped_pending;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur         <= S_CLR2;
      remain      <= C_LD;
      ped_pending <= 1'b0;
    end else begin
      if (enter_walk)
        ped_pending <= 1'b0;
      else if (cur != S_WALK && ped_req)
        ped_pending <= 1'b1;

      case (cur)
        S_NS_G, S_EW_G: begin
          if (emerg || cut_green || expire) begin
            cur    <= (cur == S_NS_G) ? S_NS_Y : S_EW_Y;
            remain <= Y_LD;
          end else if (tick) begin
            remain <= remain - ONE;
          end
        end
        S_NS_Y, S_EW_Y: begin
          if (expire) begin
            cur    <= (cur == S_NS_Y) ? S_CLR1 : S_CLR2;
            remain <= C_LD;
          end else if (tick) begin
            remain <= remain - ONE;
          end
        end
        S_CLR1: begin
          if (expire) begin
            cur    <= emerg ? S_EMERG : S_EW_G;
            remain <= emerg ? '0 : G_LD;
          end else if (tick) begin
            remain <= remain - ONE;
          end
        end
        S_CLR2: begin
          if (expire) begin
            if (emerg) begin
              cur    <= S_EMERG;
              remain <= '0;
            end else if (ped_pending) begin
              cur    <= S_WALK;
              remain <= W_LD;
            end else begin
              cur    <= S_NS_G;
              remain <= G_LD;
            end
          end else if (tick) begin
            remain <= remain - ONE;
          end
        end
        S_WALK: begin
          if (emerg) begin
            cur    <= S_EMERG;
            remain <= '0;
          end else if (expire) begin
            cur    <= S_NS_G;
            remain <= G_LD;
          end else if (tick) begin
            remain <= remain - ONE;
          end
        end
        default: begin
          remain <= '0;
          if (!emerg) begin
            cur    <= S_CLR2;
            remain <= C_LD;
          end
        end
      endcase
    end
  end

  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    case (cur)
      S_NS_G: begin ns_red = 1'b0; ns_green  = 1'b1; end
      S_NS_Y: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      S_EW_G: begin ew_red = 1'b0; ew_green  = 1'b1; end
      S_EW_Y: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      S_WALK: walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Randomized bench for traffic_phase_sched: a tick-counting phase model feeds
// an expected queue that a monitor drains one cycle at a time.
module tb_traffic_phase_sched;

  localparam int GREEN_T   = 30;
  localparam int YELLOW_T  = 5;
  localparam int CLEAR_T   = 2;
  localparam int WALK_T    = 12;
  localparam int MIN_GREEN = 10;
  localparam int CW        = 6;
  localparam int W         = 3 + CW + 8;

  localparam int P_NS_G = 0, P_NS_Y = 1, P_CLR1 = 2, P_EW_G = 3,
                 P_EW_Y = 4, P_CLR2 = 5, P_WALK = 6, P_EMERG = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          ped_req = 1'b0;
  logic          emerg = 1'b0;
  logic          ns_red, ns_yellow, ns_green;
  logic          ew_red, ew_yellow, ew_green;
  logic          walk;
  logic [CW-1:0] remain;
  logic [2:0]    state;
  logic          ped_pending;

  traffic_phase_sched #(
    .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .CLEAR_T(CLEAR_T),
    .WALK_T(WALK_T), .MIN_GREEN(MIN_GREEN), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .emerg(emerg),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .remain(remain), .state(state), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // Model: the phase plus how many ticks of it have already elapsed.
  int m_phase   = P_CLR2;
  int m_elapsed = 0;
  bit m_pend    = 1'b0;

  function automatic int dur(input int p);
    case (p)
      P_NS_G, P_EW_G: dur = GREEN_T;
      P_NS_Y, P_EW_Y: dur = YELLOW_T;
      P_CLR1, P_CLR2: dur = CLEAR_T;
      P_WALK:         dur = WALK_T;
      default:        dur = 1;
    endcase
  endfunction

  function automatic logic [6:0] lamps(input int p);
    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    case (p)
      P_NS_G:  lamps = 7'b001_100_0;
      P_NS_Y:  lamps = 7'b010_100_0;
      P_EW_G:  lamps = 7'b100_001_0;
      P_EW_Y:  lamps = 7'b100_010_0;
      P_WALK:  lamps = 7'b100_100_1;
      default: lamps = 7'b100_100_0;
    endcase
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [CW-1:0] r;
    r = (m_phase == P_EMERG) ? '0 : CW'(dur(m_phase) - 1 - m_elapsed);
    model_vec = {3'(m_phase), r, lamps(m_phase), m_pend};
  endfunction

  task automatic model_step(input bit r_n, input bit t, input bit p, input bit e);
    int np, ne, done;
    np = m_phase;
    ne = m_elapsed;
    done = m_elapsed + 1;
    if (!r_n) begin
      m_phase = P_CLR2; m_elapsed = 0; m_pend = 1'b0;
      return;
    end
    case (m_phase)
      P_NS_G, P_EW_G: begin
        if (e || (t && (done == GREEN_T || (m_pend && done >= MIN_GREEN)))) begin
          np = m_phase + 1; ne = 0;
        end else if (t) ne = done;
      end
      P_NS_Y, P_EW_Y: begin
        if (t && done == YELLOW_T) begin
          np = (m_phase == P_NS_Y) ? P_CLR1 : P_CLR2; ne = 0;
        end else if (t) ne = done;
      end
      P_CLR1, P_CLR2: begin
        if (t && done == CLEAR_T) begin
          ne = 0;
          if (e) np = P_EMERG;
          else if (m_phase == P_CLR1) np = P_EW_G;
          else np = m_pend ? P_WALK : P_NS_G;
        end else if (t) ne = done;
      end
      P_WALK: begin
        if (e) begin np = P_EMERG; ne = 0; end
        else if (t && done == WALK_T) begin np = P_NS_G; ne = 0; end
        else if (t) ne = done;
      end
      default: begin
        if (!e) begin np = P_CLR2; ne = 0; end
      end
    endcase
    if (np == P_WALK && m_phase != P_WALK) m_pend = 1'b0;
    else if (m_phase != P_WALK && p) m_pend = 1'b1;
    m_phase = np;
    m_elapsed = ne;
  endtask

  // Drive one clock worth of inputs and queue what the outputs must become.
  task automatic drive_cycle(input bit r_n, input bit t, input bit p, input bit e);
    @(posedge clk);
    #2;
    rst = r_n; tick = t; ped_req = p; emerg = e;
    model_step(r_n, t, p, e);
    exp_q.push_back(model_vec());
  endtask

  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {state, remain, ns_red, ns_yellow, ns_green,
                 ew_red, ew_yellow, ew_green, walk, ped_pending};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs @%0d: got state=%0d remain=%0d lamps=%b ped=%b, want state=%0d remain=%0d lamps=%b ped=%b",
                   cycle, act_v[W-1 -: 3], act_v[W-4 -: CW], act_v[7:1], act_v[0],
                   exp_v[W-1 -: 3], exp_v[W-4 -: CW], exp_v[7:1], exp_v[0]);
        end
        vectors++;
        if ((ns_red + ns_yellow + ns_green) != 1 || (ew_red + ew_yellow + ew_green) != 1 ||
            (!ns_red && !ew_red)) begin
          miscompares++;
          $display("FAIL lamp_exclusive @%0d: got ns=%b%b%b ew=%b%b%b, want one lamp per road and a red on one",
                   cycle, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green);
        end
      end
    end
  end

  initial begin
    bit e_lvl;
    // reset then free-running sequence with a tick every cycle
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    // sparse ticks, occasional peds, emergency episodes, rare resets
    e_lvl = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(59, 0) == 0) e_lvl = ~e_lvl;
      drive_cycle($urandom_range(499, 0) != 0, $urandom_range(1, 0) == 1,
                  $urandom_range(39, 0) == 0, e_lvl);
    end
    // ticks stalled while a ped request arrives
    for (int i = 0; i < 100; i++) drive_cycle(1'b1, 1'b0, (i == 50), 1'b0);
    // ped button held down through several WALK entries
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    // dense ticks with random peds and emergencies
    e_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) == 0) e_lvl = ~e_lvl;
      drive_cycle($urandom_range(999, 0) != 0, 1'b1, $urandom_range(29, 0) == 0, e_lvl);
    end
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sched.md
Name: traffic_phase_sched

Overview:
Phase scheduler for the two-road (NS/EW) intersection. It sequences green/yellow/all-red clearance phases from a registered state machine and a tick-driven countdown timer. It also serves a latched pedestrian request with an all-red WALK phase, and an emergency override that drains traffic to all-red. Its outputs drive the lamp drivers and the countdown display.

Parameters:
GREEN_T, 30, green phase length in ticks (each direction)
YELLOW_T, 5, yellow phase length in ticks
CLEAR_T, 2, all-red clearance length in ticks
WALK_T, 12, pedestrian walk length in ticks
MIN_GREEN, 10, minimum green ticks before a pending ped request may cut green short (1 ≤ MIN_GREEN ≤ GREEN_T)
CW, 6, countdown width; every *_T must be ≤ 2^CW

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
tick  in  1  one-cycle timing enable (1 Hz strobe)
ped_req  in  1  pedestrian button, level or pulse
emerg  in  1  emergency override, level
ns_red, ns_yellow, ns_green  out  1 each  NS lamps
ew_red, ew_yellow, ew_green  out  1 each  EW lamps
walk  out  1  pedestrian walk lamp
remain  out  CW  ticks remaining in current phase minus 1
state  out  3  current phase code
ped_pending  out  1  latched pedestrian request

Behaviour:
- One clock, clk. rst is sampled on rising clk only; active-low, synchronous.
- Reset values: state=CLR2, remain=CLEAR_T-1, ped_pending=0. This gives ns_red=ew_red=1, all other lamps 0, walk=0.
- State codes: NS_G=0, NS_Y=1, CLR1=2, EW_G=3, EW_Y=4, CLR2=5, WALK=6, EMERG=7.
- Lamp decode is combinational from the registered state:
  - NS_G: ns_green+ew_red.
  - NS_Y: ns_yellow+ew_red.
  - EW_G: ew_green+ns_red.
  - EW_Y: ew_yellow+ns_red.
  - CLR1/CLR2/EMERG: both red.
  - WALK: both red + walk.
  - Exactly one lamp per road is lit in every state.
- Normal sequence: NS_G→NS_Y→CLR1→EW_G→EW_Y→CLR2. From CLR2, go to WALK if ped_pending, else NS_G. WALK→NS_G.
- Timer:
  - Cycles with tick=0: remain and state hold.
  - On tick with remain≠0: remain decrements by 1.
  - On tick with remain==0: advance state and load remain with (next duration)-1, all in the same clock. A phase therefore lasts exactly *_T ticks.
- Ped latch:
  - ped_req=1 sets ped_pending on the next clock.
  - On the clock that enters WALK, ped_pending clears. A request in that same cycle is dropped (clear wins).
  - ped_req is ignored while in WALK.
- Green truncation: in NS_G or EW_G, on a tick with ped_pending=1 and remain ≤ GREEN_T-MIN_GREEN, advance to the yellow state immediately. Green then lasts exactly MIN_GREEN ticks, or the remaining time if the request arrived later.
- Emergency (emerg is sampled every clock; it needs no tick):
  - In NS_G/EW_G: go to the matching yellow on the next clock, remain=YELLOW_T-1.
  - In a yellow state: the yellow runs to completion.
  - In CLR1/CLR2 at expiry: go to EMERG instead of the normal successor.
  - In WALK: go to EMERG on the next clock. walk drops and ped_pending stays clear.
  - EMERG holds while emerg=1, with remain held at 0. On the first clock with emerg=0, go to CLR2 with remain=CLEAR_T-1.
  - ped_pending keeps latching during emergency.
- Precedence within one clock: rst > emerg > ped truncation > timer expiry.
- Reset mid-phase: returns to the reset state on the next clock regardless of tick or emerg.

Test Plan:
1. Defaults, tick every cycle, no inputs, from reset → CLR2 for 2 ticks, NS_G 30, NS_Y 5, CLR1 2, EW_G 30, EW_Y 5, CLR2 2; repeats with period 74 ticks; never two greens or green+yellow across roads.
2. Pulse ped_req at NS_G remain=27 → ped_pending=1; NS_Y entered on the tick where remain=20 (10 green ticks); sequence then runs through CLR1, EW_G (truncated to 10), EW_Y, CLR2, WALK for 12 ticks with walk=1, then NS_G; ped_pending=0 on WALK entry.
3. emerg=1 mid EW_G (remain=15) → EW_Y next clock with remain=4; CLR2 after 5 ticks; EMERG after 2 ticks; held 50 cycles; emerg=0 → CLR2 remain=1, then NS_G.
4. tick held low 100 cycles in NS_Y remain=3 → state/remain unchanged; ped_req pulse still sets ped_pending.
5. rst=0 for one clock during WALK remain=5 → next clock state=5, remain=1, walk=0, ped_pending=0, both reds.
6. ped_req held high across the WALK-entry clock → ped_pending=0 after entry; stays 0 through the end of WALK; sets again once in NS_G if still held.
